// File: rtl/issue_ctrl_pkg.sv
// Shared processor definitions: opcode constants, controller state encoding
// and decode helpers used by the issue controller and the execution units.
package issue_ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int OPC_W  = 4;

  localparam logic [OPC_W-1:0] OPC_NOP  = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_OR   = 4'b1101;
  localparam logic [OPC_W-1:0] OPC_HALT = 4'b1111;

  typedef enum logic [2:0] {
    ST_FETCH_OP  = 3'd0,
    ST_FETCH_IMM = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT      = 3'd3,
    ST_WB        = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  // Anything that is not NOP/LDI/HALT goes to an execution unit with an immediate.
  function automatic logic is_exec_op(input logic [OPC_W-1:0] op);
    return !(op == OPC_NOP || op == OPC_LDI || op == OPC_HALT);
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Program-memory and execution-unit bus between the issue controller (master)
// and the memory / execution units (slave).
interface issue_ctrl_if;
  import issue_ctrl_pkg::*;

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] instr_in;
  logic [OPC_W-1:0]  ctr1;
  logic [DATA_W-1:0] data1;
  logic [DATA_W-1:0] data2;
  logic [DATA_W-1:0] exec_out;
  logic              exec_done;

  modport master (
    output pc, ctr1, data1, data2,
    input  instr_in, exec_out, exec_done
  );

  modport slave (
    input  pc, ctr1, data1, data2,
    output instr_in, exec_out, exec_done
  );

endinterface

// File: rtl/issue_ctrl.sv
// Instruction fetch/issue controller: fetches opcode and immediate bytes, issues
// execution-unit ops, waits for a fresh done edge (with timeout) and writes acc.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int               TIMEOUT = 8,
  parameter logic [OPC_W-1:0] OP_NOP  = 4'b0000
) (
  input  logic              clk,
  input  logic              rst,
  issue_ctrl_if.master      bus,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] data1_q;
  logic [DATA_W-1:0] data2_q;
  logic [DATA_W-1:0] result_q;
  logic [OPC_W-1:0]  op_q;
  logic [OPC_W-1:0]  ctr1_q;
  logic              halted_q;
  logic              err_q;
  logic              done_prev_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [CNT_W-1:0]  wait_cnt_d;
  logic [OPC_W-1:0]  opcode;
  logic              done_edge;
  logic              unused_instr_lo;

  assign opcode          = bus.instr_in[DATA_W-1 -: OPC_W];
  assign unused_instr_lo = ^bus.instr_in[DATA_W-OPC_W-1:0];
  // A done level already high when WAIT is entered is not an edge.
  assign done_edge       = bus.exec_done & ~done_prev_q;
  assign wait_cnt_d      = wait_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FETCH_OP;
      pc_q        <= '0;
      acc_q       <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      result_q    <= '0;
      op_q        <= OPC_NOP;
      ctr1_q      <= OP_NOP;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      wait_cnt_q  <= '0;
      done_prev_q <= 1'b0;
    end else begin
      done_prev_q <= bus.exec_done;
      ctr1_q      <= OP_NOP;
      unique case (state_q)
        ST_FETCH_OP: begin
          op_q <= opcode;
          pc_q <= pc_q + 1'b1;
          if (opcode == OPC_HALT) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else if (opcode != OPC_NOP) begin
            state_q <= ST_FETCH_IMM;
          end
        end
        ST_FETCH_IMM: begin
          data1_q <= bus.instr_in;
          pc_q    <= pc_q + 1'b1;
          // ctr1 is registered here so it is visible exactly during ISSUE.
          if (is_exec_op(op_q)) begin
            ctr1_q  <= op_q;
            data2_q <= acc_q;
            state_q <= ST_ISSUE;
          end else begin
            acc_q   <= bus.instr_in;
            state_q <= ST_FETCH_OP;
          end
        end
        ST_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_edge) begin
            result_q <= bus.exec_out;
            state_q  <= ST_WB;
          end else if (wait_cnt_d == CNT_W'(TIMEOUT)) begin
            err_q   <= 1'b1;
            state_q <= ST_FETCH_OP;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        ST_WB: begin
          acc_q   <= result_q;
          state_q <= ST_FETCH_OP;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH_OP;
      endcase
    end
  end

  assign bus.pc    = pc_q;
  assign bus.ctr1  = ctr1_q;
  assign bus.data1 = data1_q;
  assign bus.data2 = data2_q;
  assign acc       = acc_q;
  assign halted    = halted_q;
  assign err       = err_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: a program-level reference model predicts the
// timed event stream (issue, acc change, err, halt); a negedge monitor checks it.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int         TO     = 8;
  localparam logic [3:0] IDLE   = 4'b0000;
  localparam int         K_ISSUE = 0;
  localparam int         K_ACC   = 1;
  localparam int         K_ERR   = 2;
  localparam int         K_HALT  = 3;
  localparam int         NO_STOP = 1 << 30;

  typedef struct {
    int          kind;
    logic [27:0] val;
    int          cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] acc;
  logic       halted;
  logic       err;

  issue_ctrl_if bus ();

  issue_ctrl #(.TIMEOUT(TO), .OP_NOP(IDLE)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .acc    (acc),
    .halted (halted),
    .err    (err)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  assign bus.instr_in = mem[bus.pc];

  ev_t         exp_q[$];
  logic [15:0] wq[$];
  logic [15:0] dq[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic        mon_en      = 1'b0;
  int          mcyc        = 0;
  logic [7:0]  prev_acc;
  logic        prev_err;
  logic        prev_halt;
  logic [7:0]  halt_pc;

  // Execution-unit result rule: OR unit ORs, other units use a keyed mix.
  function automatic logic [7:0] exec_res(input logic [3:0] op, input logic [7:0] d1,
                                          input logic [7:0] d2);
    if (op == OPC_OR) return d1 | d2;
    return (d1 + d2) ^ {op, op};
  endfunction

  // Done waveform indexed by cycles after ISSUE (bit 0 = the ISSUE cycle itself).
  function automatic logic [15:0] gen_wave();
    logic [15:0] w;
    int d, h, a, b;
    w = '0;
    case ($urandom_range(0, 4))
      0: begin
        d = $urandom_range(1, TO + 1);
        h = $urandom_range(1, 4);
        for (int t = d; t < d + h && t < 16; t++) w[t] = 1'b1;
      end
      1: w = 16'hFFFF;
      2: begin
        a = $urandom_range(1, 3);
        b = a + $urandom_range(1, 5);
        for (int t = 0; t < a; t++) w[t] = 1'b1;
        for (int t = b; t < 16; t++) w[t] = 1'b1;
      end
      3: w = 16'($urandom);
      default: w = '0;
    endcase
    return w;
  endfunction

  task automatic push_ev(input int kind, input logic [27:0] val, input int cyc, input int stop);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = cyc;
    if (cyc < stop) exp_q.push_back(e);
  endtask

  // Program-level model: cycle costs NOP 1, LDI 2, HALT visible next cycle,
  // exec op completes 4+j cycles after fetch (j = WAIT cycle of first fresh
  // rising done edge), or times out after TO WAIT cycles.
  task automatic model_run(input int stop);
    logic [7:0]  p, a, imm, res;
    logic [3:0]  op;
    logic        e;
    logic [15:0] w;
    int          c, j;
    p = 8'h00; a = 8'h00; e = 1'b0; c = 0;
    while (c < 20000) begin
      op = mem[p][7:4];
      p  = p + 8'd1;
      if (op == OPC_NOP) begin
        c += 1;
        continue;
      end
      if (op == OPC_HALT) begin
        push_ev(K_HALT, {20'h0, p}, c + 1, stop);
        halt_pc = p;
        break;
      end
      imm = mem[p];
      p   = p + 8'd1;
      if (op == OPC_LDI) begin
        if (imm != a) push_ev(K_ACC, {12'h0, p, imm}, c + 2, stop);
        a  = imm;
        c += 2;
        continue;
      end
      push_ev(K_ISSUE, {p, op, imm, a}, c + 2, stop);
      w = (dq.size() > 0) ? dq.pop_front() : gen_wave();
      wq.push_back(w);
      j = 0;
      for (int t = 1; t <= TO; t++) if (j == 0 && w[t] && !w[t-1]) j = t;
      if (j != 0) begin
        res = exec_res(op, imm, a);
        if (res != a) push_ev(K_ACC, {12'h0, p, res}, c + 4 + j, stop);
        a  = res;
        c += 4 + j;
      end else begin
        if (!e) push_ev(K_ERR, {20'h0, p}, c + 3 + TO, stop);
        e  = 1'b1;
        c += 3 + TO;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_ev(input int kind, input logic [27:0] val);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_ev: kind %0d val %h cyc %0d, required none", kind, val, mcyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== val || e.cyc != mcyc) begin
        miscompares++;
        $display("FAIL ev_cmp: got kind %0d val %h cyc %0d, required kind %0d val %h cyc %0d",
                 kind, val, mcyc, e.kind, e.val, e.cyc);
      end else begin
        $display("ev kind %0d val %h cyc %0d ok", kind, val, mcyc);
      end
    end
  endtask

  // Monitor: turns observable DUT activity into events and scores them.
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < mcyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missed_ev: kind %0d val %h not seen, required at cyc %0d",
                 exp_q[0].kind, exp_q[0].val, exp_q[0].cyc);
        exp_q.delete(0);
      end
      if (bus.ctr1 != IDLE) check_ev(K_ISSUE, {bus.pc, bus.ctr1, bus.data1, bus.data2});
      if (acc != prev_acc) check_ev(K_ACC, {12'h0, bus.pc, acc});
      if (err && !prev_err) check_ev(K_ERR, {20'h0, bus.pc});
      if (halted && !prev_halt) check_ev(K_HALT, {20'h0, bus.pc});
      prev_acc  = acc;
      prev_err  = err;
      prev_halt = halted;
      mcyc++;
    end
  end

  // Execution unit: replays the per-issue done waveform, result only while done.
  initial begin
    logic [15:0] xwave;
    int          xt;
    logic [3:0]  xop;
    xwave = '0; xt = 15; xop = '0;
    bus.exec_done = 1'b0;
    bus.exec_out  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.ctr1 != IDLE) begin
        xt    = 0;
        xop   = bus.ctr1;
        xwave = (wq.size() > 0) ? wq.pop_front() : 16'h0000;
      end else if (xt < 15) begin
        xt++;
      end
      bus.exec_done = xwave[xt];
      bus.exec_out  = xwave[xt] ? exec_res(xop, bus.data1, bus.data2) : 8'($urandom);
    end
  end

  task automatic prep();
    exp_q.delete();
    wq.delete();
    dq.delete();
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
  endtask

  task automatic start_run();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_pc", bus.pc, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ctr1", bus.ctr1, IDLE);
    chk("rst_data1", bus.data1, 0);
    chk("rst_data2", bus.data2, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    mcyc      = 0;
    prev_acc  = 8'h00;
    prev_err  = 1'b0;
    prev_halt = 1'b0;
    mon_en    = 1'b1;
  endtask

  task automatic finish_run(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("halt_wait", halted, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("halt_pc_frozen", bus.pc, halt_pc);
    chk("halt_ctr1", bus.ctr1, IDLE);
    mon_en = 1'b0;
    chk("events_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic gen_prog();
    int         p, n, k;
    logic [3:0] lo, op;
    p = 0;
    n = $urandom_range(6, 14);
    for (int i = 0; i < n; i++) begin
      k  = $urandom_range(0, 9);
      lo = 4'($urandom);
      if (k < 2) begin
        mem[p] = {OPC_NOP, lo};
        p += 1;
      end else begin
        op = (k < 4) ? OPC_LDI : (k < 8) ? OPC_OR : 4'($urandom_range(2, 14));
        mem[p]     = {op, lo};
        mem[p + 1] = 8'($urandom);
        p += 2;
      end
    end
    mem[p] = {OPC_HALT, 4'($urandom)};
  endtask

  initial begin
    // OR-unit program: LDI 0F, OR F0, HALT.
    prep();
    mem[0] = 8'h10; mem[1] = 8'h0F; mem[2] = 8'hD0; mem[3] = 8'hF0; mem[4] = 8'hF0;
    dq.push_back(16'h000E);
    model_run(NO_STOP);
    start_run();
    finish_run(200);

    // Done stuck high through the op: timeout, acc kept, next opcode runs.
    prep();
    mem[0] = 8'h10; mem[1] = 8'h33; mem[2] = 8'hD0; mem[3] = 8'h44;
    mem[4] = 8'h1A; mem[5] = 8'h77; mem[6] = 8'hF3;
    dq.push_back(16'hFFFF);
    model_run(NO_STOP);
    start_run();
    finish_run(200);

    // Back-to-back ORs with done high across both.
    prep();
    mem[0] = 8'h10; mem[1] = 8'h0A; mem[2] = 8'hD5; mem[3] = 8'h30;
    mem[4] = 8'hDA; mem[5] = 8'h05; mem[6] = 8'hF0;
    dq.push_back(16'hFFFC);
    dq.push_back(16'hFFF3);
    model_run(NO_STOP);
    start_run();
    finish_run(200);

    // pc wrap: NOPs up to 0xFE, LDI at 0xFF takes its immediate from 0x00.
    prep();
    mem[0] = 8'h3C; mem[1] = 8'hF0;
    for (int i = 2; i < 255; i++) mem[i] = 8'h00;
    mem[255] = 8'h10;
    dq.push_back(16'h0002);
    model_run(NO_STOP);
    start_run();
    finish_run(2000);

    // Reset during WAIT after an earlier timeout; late done pulse must not land.
    prep();
    mem[0] = 8'hD0; mem[1] = 8'h0F; mem[2] = 8'h10; mem[3] = 8'h55;
    mem[4] = 8'hD1; mem[5] = 8'h0F; mem[6] = 8'hF0;
    dq.push_back(16'h0000);
    dq.push_back(16'h0060);
    model_run(17);
    start_run();
    repeat (17) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("pre_rst_events", exp_q.size(), 0);
    chk("pre_rst_err", err, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("wait_rst_pc", bus.pc, 0);
    chk("wait_rst_acc", acc, 0);
    chk("wait_rst_ctr1", bus.ctr1, IDLE);
    chk("wait_rst_err", err, 0);
    chk("wait_rst_data1", bus.data1, 0);
    chk("wait_rst_data2", bus.data2, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("late_done_acc", acc, 0);
    chk("late_done_err", err, 0);
    chk("late_done_halted", halted, 0);

    // Randomised programs.
    for (int r = 0; r < 25; r++) begin
      prep();
      gen_prog();
      model_run(NO_STOP);
      start_run();
      finish_run(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 8: maximum WAIT cycles allowed for exec_done before the instruction is aborted.
REQ-002 Parameter OP_NOP, default 4'b0000: idle opcode driven on ctr1 whenever no instruction is being issued.
REQ-003 clk  input  1  single system clock; all state changes on its posedge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 instr_in  input  8  program-memory byte at address pc; combinational read, valid in the same cycle.
REQ-006 pc  output  8  program counter; drives the program-memory address.
REQ-007 ctr1  output  4  opcode to the execution units; the OR unit responds to 4'b1101.
REQ-008 data1  output  8  immediate operand to the execution units.
REQ-009 data2  output  8  accumulator operand to the execution units.
REQ-010 exec_out  input  8  result from the execution units.
REQ-011 exec_done  input  1  completion flag from the execution units; may stay high for several cycles.
REQ-012 acc  output  8  accumulator register.
REQ-013 halted  output  1  high while in HALT.
REQ-014 err  output  1  sticky timeout flag.

Function
REQ-015 The instruction byte SHALL be decoded as opcode = instr_in[7:4]; bits [3:0] are ignored.
REQ-016 4'b0000 SHALL decode as NOP, 4'b0001 as LDI (load immediate), 4'b1111 as HALT, and every other code as an execution-unit op with an immediate.
REQ-017 The FSM SHALL have the states FETCH_OP, FETCH_IMM, ISSUE, WAIT, WB and HALT.
REQ-018 FETCH_OP SHALL latch the opcode and set pc <= pc+1, then go to:
  - FETCH_OP for NOP;
  - HALT for HALT;
  - FETCH_IMM for all other opcodes.
REQ-019 FETCH_IMM SHALL latch instr_in into data1 and set pc <= pc+1.
  - LDI: acc <= instr_in, next state FETCH_OP.
  - Other opcodes: next state ISSUE.
REQ-020 In ISSUE, the block SHALL:
  - drive ctr1 = latched opcode for exactly one cycle;
  - set data2 = acc;
  - go to WAIT.
REQ-021 Outside ISSUE, ctr1 SHALL equal OP_NOP.
REQ-022 data1 and data2 SHALL remain stable from ISSUE until leaving WAIT.
REQ-023 WAIT SHALL detect the rising edge of exec_done (current 1, registered previous value 0).
  - On that edge: capture exec_out and go to WB.
  - A level that was already high on entry to WAIT SHALL NOT count as completion.
REQ-024 A WAIT cycle counter SHALL start from 0 on entry to WAIT.
  - When it reaches TIMEOUT without a done edge: set err=1, leave acc unchanged, go to FETCH_OP.
REQ-025 WB SHALL write acc <= captured result and go to FETCH_OP.
REQ-026 HALT SHALL be absorbing until rst: halted=1, pc frozen, ctr1=OP_NOP.
REQ-027 pc SHALL wrap from 8'hFF to 8'h00 without a flag; an immediate fetched across the wrap comes from address 0.
REQ-028 The latency of an execution op with a done edge k cycles after ISSUE SHALL be 3+k+1 cycles from FETCH_OP entry to acc update.
  - LDI SHALL take 2 cycles.
  - NOP SHALL take 1 cycle.

Reset
REQ-029 On rst=1 at a posedge, the block SHALL set:
  - state=FETCH_OP, pc=0, acc=0, data1=0, data2=0;
  - ctr1=OP_NOP, halted=0, err=0;
  - wait counter=0, registered exec_done=0.
REQ-030 rst SHALL take priority over every state, including WAIT and HALT; any in-flight result is discarded.

Structure
REQ-031 The opcode constants (NOP, LDI, OR=4'b1101, HALT) and the FSM state encoding SHALL live in a shared processor package used by the execution units.
REQ-032 The block SHALL be a single module with no sub-modules; the done-edge detector stays inline.

Verification
REQ-033 Program {0x10,0x0F,0xD0,0xF0,0xF0}, with an OR-unit model that raises done 1 cycle after issue and holds it 3 cycles, SHALL give:
  - ctr1=4'b1101 for one cycle, data1=0xF0, data2=0x0F;
  - acc=0xFF, then halted=1 with pc=5.
REQ-034 OR op with exec_done held high from before ISSUE and no new edge SHALL give err=1 after 8 WAIT cycles, acc unchanged, and the next opcode fetched.
REQ-035 rst asserted mid-WAIT SHALL give, on the next cycle, pc=0, acc=0, ctr1=0, err=0, with the late done pulse ignored.
REQ-036 pc preset to 0xFE by executing NOPs, with LDI at 0xFF and 0x3C at 0x00, SHALL give acc=0x3C and pc=1.
REQ-037 Back-to-back OR ops where done stays high across both SHALL complete the second only on a fresh rising edge.
